// File: rtl/cam_pkg.sv
// Shared frame-buffer geometry, capture state and RGB565 pixel type for the camera
// capture stage and the VGA scan-out stage.
package cam_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_W    = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

  // The camera sends the high byte first, so the pair concatenates directly.
  function automatic rgb565_t rgb565_from_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs consecutive HREF bytes into one RGB565 pixel; o_pix_valid marks the cycle
// in which the second byte of a pair is presented.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       i_active,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_pix_valid,
  output rgb565_t    o_pixel
);

  logic       r_phase;
  logic [7:0] r_hi_byte;

  // Phase drops back to 0 whenever HREF is low, so an odd trailing byte is discarded.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_phase   <= 1'b0;
      r_hi_byte <= 8'h00;
    end else if (!i_active || !i_href) begin
      r_phase <= 1'b0;
    end else if (!r_phase) begin
      r_hi_byte <= i_data;
      r_phase   <= 1'b1;
    end else begin
      r_phase <= 1'b0;
    end
  end

  assign o_pix_valid = i_active & i_href & r_phase;
  assign o_pixel     = rgb565_from_bytes(r_hi_byte, i_data);

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: frame sync FSM, linear frame-buffer address counter and status flags.
// Build option CAPTURE_DECIMATE_EN: VGA source, only even pixels of even lines are stored.
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int P_FB_DEPTH = FB_DEPTH
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [ADDR_W-1:0] frame_pixels,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(P_FB_DEPTH);

  cap_state_t        r_state;
  logic              r_vs_q;
  logic              r_vs_d;
  logic              r_href_q;
  logic [7:0]        r_d_q;
  logic [ADDR_W-1:0] r_addr;
  logic              w_vs_rise;
  logic              w_vs_fall;
  logic              w_capturing;
  logic              w_pix_valid;
  logic              w_keep;
  rgb565_t           w_pixel;

  // Register the camera pins; all decisions below use these copies.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vs_q   <= 1'b0;
      r_vs_d   <= 1'b0;
      r_href_q <= 1'b0;
      r_d_q    <= 8'h00;
    end else begin
      r_vs_q   <= cam_vsync;
      r_vs_d   <= r_vs_q;
      r_href_q <= cam_href;
      r_d_q    <= cam_data;
    end
  end

  assign w_vs_rise = r_vs_q & ~r_vs_d;
  assign w_vs_fall = ~r_vs_q & r_vs_d;
  // Frame end beats a pixel completing in the same cycle.
  assign w_capturing = (r_state == CAPTURE) & ~w_vs_rise;

  cam_byte_pack u_pack (
    .pclk        (pclk),
    .rst         (rst),
    .i_active    (w_capturing),
    .i_href      (r_href_q),
    .i_data      (r_d_q),
    .o_pix_valid (w_pix_valid),
    .o_pixel     (w_pixel)
  );

`ifdef CAPTURE_DECIMATE_EN
  logic r_href_d;
  logic r_line_par;
  logic r_pix_par;

  // Line parity counts HREF falls since VSYNC; pixel parity restarts on every line.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_href_d   <= 1'b0;
      r_line_par <= 1'b0;
      r_pix_par  <= 1'b0;
    end else begin
      r_href_d <= r_href_q;
      if (w_vs_fall) begin
        r_line_par <= 1'b0;
      end else if (r_href_d && !r_href_q) begin
        r_line_par <= ~r_line_par;
      end
      if (!r_href_q) begin
        r_pix_par <= 1'b0;
      end else if (w_pix_valid) begin
        r_pix_par <= ~r_pix_par;
      end
    end
  end

  assign w_keep = w_pix_valid & ~r_line_par & ~r_pix_par;
`else
  assign w_keep = w_pix_valid;
`endif

  // Frame FSM with address counter and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 16'h0000;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= SYNC;
            busy    <= 1'b1;
          end
        end
        SYNC: begin
          if (w_vs_fall) begin
            r_state  <= CAPTURE;
            r_addr   <= '0;
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_vs_rise) begin
            frame_done   <= 1'b1;
            frame_pixels <= r_addr;
            r_state      <= enable ? SYNC : IDLE;
            busy         <= enable;
          end else if (w_keep) begin
            if (r_addr < LP_DEPTH) begin
              wr_en   <= 1'b1;
              wr_addr <= r_addr;
              wr_data <= w_pixel;
              r_addr  <= r_addr + ADDR_W'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Camera-side capture stage that writes the 320x240 RGB565 frame buffer read by the VGA scan-out stage.
- Samples the OV7670 parallel bus (VSYNC, HREF, 8-bit data) on the camera pixel clock.
- Packs each byte pair into one 16-bit pixel and issues one linear write per pixel at addresses 0..76799.
- Runs entirely in the camera clock domain; the frame buffer is dual-clock, so no CDC logic lives here.

Parameters:
- FB_WIDTH, 320, pixels per stored line.
- FB_HEIGHT, 240, stored lines per frame.
- FB_DEPTH, 76800, FB_WIDTH*FB_HEIGHT; last valid address is FB_DEPTH-1.
- ADDR_W, 17, width of the write address and pixel counts.

Ports:
- pclk  in  1  camera pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arms capture; a change takes effect only at a frame boundary.
- cam_vsync  in  1  OV7670 VSYNC, active-high during vertical blank.
- cam_href  in  1  OV7670 HREF, high while line bytes are valid.
- cam_data  in  8  OV7670 D[7:0].
- wr_en  out  1  frame-buffer write strobe, one cycle per pixel.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  16  RGB565 pixel: {first byte, second byte}.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_pixels  out  ADDR_W  pixel count of the last completed frame.
- busy  out  1  high in SYNC or CAPTURE state.
- overflow  out  1  sticky: the frame delivered more than FB_DEPTH pixels.

Behaviour:
- Reset, asynchronous:
  - All outputs are 0.
  - Internal registers are cleared: vs_q, href_q, d_q, phase, hi_byte, addr.
  - state = IDLE.
  - Reset mid-frame abandons the frame. No further writes occur until a complete VSYNC high-then-low sequence is seen.
- Input stage: cam_vsync, cam_href and cam_data are registered every cycle into vs_q, href_q, d_q. All decisions use the _q values. vs_rise and vs_fall are derived against a one-cycle-delayed copy of vs_q.
- FSM:
  - IDLE: if enable, go to SYNC.
  - SYNC: wait for vs_fall, then go to CAPTURE with addr=0, phase=0, overflow cleared.
  - CAPTURE: on vs_rise:
    - pulse frame_done for one cycle;
    - frame_pixels <= addr;
    - go to SYNC if enable, else IDLE.
- Byte packing, CAPTURE only:
  - href_q=0: phase is forced to 0. An odd trailing byte on a line is dropped.
  - href_q=1 and phase=0: hi_byte <= d_q; phase <= 1.
  - href_q=1 and phase=1, with addr < FB_DEPTH:
    - wr_en <= 1; wr_addr <= addr; wr_data <= {hi_byte, d_q};
    - addr <= addr+1; phase <= 0.
  - href_q=1 and phase=1, with addr = FB_DEPTH: no write; overflow <= 1; addr holds.
- Latency: a second byte on the pins at edge n produces wr_en=1 in the cycle after edge n+1. Stated differently, the pixel is registered at edge n+1 and its write is visible at edge n+2.
- wr_en is 0 in every cycle not listed above. wr_addr and wr_data hold their last values between writes.
- Simultaneous vs_rise with href_q=1: the frame end wins. The pending half-pixel is discarded.
- A short frame (fewer than FB_DEPTH pixels) is not an error. frame_pixels reports the count.
- overflow clears only on reset or on entry to CAPTURE.
- busy = (state != IDLE).

Optional Feature:
- Macro: CAPTURE_DECIMATE_EN.
- Defined:
  - The camera runs in VGA 640x480 mode.
  - Only even pixels of even lines are written, giving 320x240.
  - A line-parity bit toggles on each href_q falling edge and resets to 0 at vs_fall.
  - A pixel-parity bit toggles per assembled pixel and resets at each line start.
  - Discarded pixels advance nothing.
- Undefined: every assembled pixel is written (camera in QVGA mode). The parity logic is absent.

Decomposition:
- Package cam_pkg holds:
  - FB_WIDTH, FB_HEIGHT, FB_DEPTH and ADDR_W constants, shared with the VGA scan-out address range;
  - the capture state typedef {IDLE, SYNC, CAPTURE};
  - the RGB565 pixel typedef.
- One sub-module is natural: cam_byte_pack. It holds phase, hi_byte and the pixel-valid strobe and is driven by href_q/d_q. The FSM, address counter and flags stay in the top module.

Test Plan:
- Nominal QVGA frame: enable=1, VSYNC pulse, then 240 lines of 640 bytes with byte pair k = {k[15:8], k[7:0]} -> 76800 writes, addr 0..76799, wr_data = k; then frame_done pulse with frame_pixels=76800, overflow=0.
- Latency check: single line with bytes 0xF8, 0x1F -> wr_en high exactly two edges after 0x1F is on the pins, wr_addr=0, wr_data=0xF81F.
- Overflow: 241 lines -> no write beyond addr 76799, overflow=1 at frame end, frame_pixels=76800; overflow=0 again after the next vs_fall.
- Odd-byte line and short frame: 3 lines of 641 bytes -> 960 writes, frame_pixels=960, no carry of the stray byte into the next line's pixel.
- Reset mid-frame: assert rst during line 100 -> outputs 0 immediately; no wr_en until a full VSYNC high/low; the next frame starts at addr 0.
- Enable drop mid-frame: enable=0 during line 50 -> the frame completes normally with frame_done, then IDLE, busy=0, no further writes. With CAPTURE_DECIMATE_EN and a 640x480 source: 76800 writes and the pixel at addr 1 equals source pixel (0,2).
